turtle_cpu_top: RTL and testbench
=================================

Name: turtle_cpu_top

Overview:
Top level of the Turtle CPU: a single-cycle, 8-bit accumulator machine with 16-bit instructions. It integrates the instruction memory, data memory, 8-entry register file, decoder, ALU and PC logic. The board controls are a reset button and a manual single-step clock (switch plus pulse button); all stepping is done with a clock enable, not a gated clock.

Parameters:
IMEM_DEPTH, 1024, instruction words (PC is 10 bits)
DMEM_DEPTH, 256, data bytes
NUM_GPR, 8, general-purpose registers of 8 bits

Ports:
clk  input  1  system clock; all state is on its rising edge
reset_btn  input  1  synchronous, active-high reset
manual_clk_sw  input  1  0 = step every clk; 1 = step only on pulse_clk_btn
pulse_clk_btn  input  1  manual step button (asynchronous, synchronised internally)
acc_out  output  8  accumulator value
halted  output  1  high once HALT has executed

Behaviour:
- Internal reset_n = ~reset_btn; reset is synchronous and active-high, with priority over stepping.
- Reset values: pc=0, acc=0, flags Z/N/C=0, halted=0, all GPRs=0. Memories are not cleared.
- step_en = 1 when manual_clk_sw=0. When manual_clk_sw=1, step_en = one-clk pulse per 0->1 edge of pulse_clk_btn, after a 2-flop synchroniser.
- All state updates only when step_en=1 and halted=0.
- instruction = imem[pc], read combinationally. Hierarchy names are fixed for benches:
  - instruction_memory_inst.mem (16-bit words)
  - data_memory_inst.mem (8-bit, async read, sync write)
  - register_file_inst.mem (8x8)
- Opcode is bits[15:13]:
  - 000 ALU_REG: acc <= acc func R[rs]; func=[12:9], rs=[2:0].
  - 001 ALU_IMM: acc <= acc func imm8; func=[12:9], imm8=[7:0].
  - 010 REG_MEMORY: func=[12:10].
    - 0 LOAD: acc <= dmem[imm8]
    - 1 STORE: dmem[imm8] <= acc
    - 2 GET: acc <= R[rs]
    - 3 PUT: R[rs] <= acc
    - 4 LOADR: acc <= dmem[R[rs]]
    - 5 STORER: dmem[R[rs]] <= acc
    - 6,7: no-op
  - 011 JUMP: pc <= [9:0], unconditional.
  - 100 BRANCH: if the condition holds, pc <= [9:0], else pc+1. cond=[12:10]: 0 Z, 1 NZ, 2 N, 3 NN, 4 C, 5 NC, 6 always, 7 never.
  - 111 HALT: halted <= 1; pc is held.
  - 101, 110: no-op.
- Every other instruction: pc <= pc+1, wrapping 1023 -> 0.
- ALU functions:
  - 0 ADD, 1 SUB (acc-op), 2 AND, 3 OR, 4 XOR, 5 NOT acc, 6 SHL, 7 SHR (logical), 8 PASS (acc <= op).
  - 9-15: acc unchanged, flags unchanged.
- Flags update only on ALU ops 0-8:
  - Z = (result == 0); N = result[7].
  - C = carry-out for ADD; borrow (acc < op) for SUB; bit shifted out for SHL/SHR; 0 otherwise.
- All arithmetic is 8-bit modulo. Branch and REG_MEMORY ops do not affect flags.
- Reset while halted clears halted and restarts at pc=0.
- manual_clk_sw may change at any time; no spurious step on the change itself.

Optional Feature:
MANUAL_CLK_EN:
- Defined: the manual_clk_sw/pulse_clk_btn stepping is present as described.
- Undefined: both inputs are ignored and step_en is constantly 1.

Test Plan:
- Reset: hold reset_btn=1 for 10 clks -> pc=0, acc_out=0x00, all GPRs=0, halted=0.
- ALU: ALU_IMM PASS 0xF0, then ALU_IMM ADD 0x20 -> acc=0x10, C=1, Z=0. Then SUB 0x10 -> acc=0x00, Z=1, C=0.
- Memory and registers:
  - PASS 0x5A, PUT R3, STORE 0x07, PASS 0, LOAD 0x07 -> acc=0x5A, R3=0x5A, dmem[7]=0x5A.
  - PUT R2 (acc=0x07), PASS 0x11, STORER R2 -> dmem[7]=0x11.
- Control flow:
  - Countdown loop: R1=3; loop body GET R1, SUB 1, PUT R1, BRANCH NZ to loop -> exits with R1=0.
  - Then JUMP 0x3F0 -> pc=0x3F0, where HALT -> halted=1, pc stays 0x3F0.
- Manual clock (MANUAL_CLK_EN defined): manual_clk_sw=1 with no pulses for 100 clks -> pc unchanged. Three button presses, each held 5 clks -> pc advances by exactly 3.
- Reset mid-program: assert reset_btn while a loop is running -> next clk pc=0, acc=0; the program restarts, and dmem contents written earlier are retained.

Source files
------------

// File: rtl/turtle_cpu_top_if.sv
// Turtle CPU board-side bundle: manual stepping controls in, accumulator and halt status out.
// Latency: pure wiring, no storage.
// Backpressure: none; controls are level/edge inputs and the status outputs are always valid.
//
// Signals:
//   manual_clk_sw  0 = free-run, 1 = step only on pulse_clk_btn presses
//   pulse_clk_btn  raw manual step button (asynchronous to clk)
//   acc_out        accumulator value
//   halted         high once HALT has retired
interface turtle_cpu_top_if;
    logic       manual_clk_sw;
    logic       pulse_clk_btn;
    logic [7:0] acc_out;
    logic       halted;

    // Board / testbench side
    modport master (
        output manual_clk_sw,
        output pulse_clk_btn,
        input  acc_out,
        input  halted
    );

    // CPU side
    modport slave (
        input  manual_clk_sw,
        input  pulse_clk_btn,
        output acc_out,
        output halted
    );
endinterface

// File: rtl/turtle_cpu_top.sv
// Turtle CPU: single-cycle 8-bit accumulator machine, 16-bit instructions, 8 GPRs, 1K imem, 256B dmem.
// Latency: one instruction retires per clk in which step_en is high and the core is not halted.
// Backpressure: none; progress is throttled only by step_en (free-run or one step per button press).
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset_btn  synchronous active-high reset, wins over stepping
//   bus        turtle_cpu_top_if.slave: manual_clk_sw, pulse_clk_btn in; acc_out, halted out
//
// Build option: define MANUAL_CLK_EN to enable the manual single-step controls; without it
// both manual inputs are ignored and the core steps on every clk.

module turtle_instruction_memory #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_dat,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_dat
);
    logic [15:0] mem [DEPTH];

    // Program load path; the top ties it off, a boot loader may use it later.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_dat;
        end
    end

    assign rd_dat = mem[rd_addr];
endmodule

module turtle_data_memory #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [7:0]    rd_dat,
    input  logic          wr_en,
    input  logic [7:0]    wr_dat
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[addr];
endmodule

module turtle_register_file #(
    parameter int NUM = 8,
    parameter int AW  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_dat,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_dat
);
    logic [7:0] mem [NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];
endmodule

module turtle_cpu_top #(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 256,
    parameter int NUM_GPR    = 8
) (
    input  logic            clk,
    input  logic            reset_btn,
    turtle_cpu_top_if.slave bus
);
    localparam int PC_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);
    localparam int RA_W = $clog2(NUM_GPR);

    typedef enum logic [2:0] {
        OP_ALU_REG = 3'd0,
        OP_ALU_IMM = 3'd1,
        OP_REG_MEM = 3'd2,
        OP_JUMP    = 3'd3,
        OP_BRANCH  = 3'd4,
        OP_NOP5    = 3'd5,
        OP_NOP6    = 3'd6,
        OP_HALT    = 3'd7
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_PASS = 4'd8
    } alu_func_e;

    typedef enum logic [2:0] {
        MEM_LOAD   = 3'd0,
        MEM_STORE  = 3'd1,
        MEM_GET    = 3'd2,
        MEM_PUT    = 3'd3,
        MEM_LOADR  = 3'd4,
        MEM_STORER = 3'd5,
        MEM_NOP6   = 3'd6,
        MEM_NOP7   = 3'd7
    } mem_func_e;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    logic reset_n;
    assign reset_n = ~reset_btn;

    // ------------------------------------------------------------------
    // Step enable
    // ------------------------------------------------------------------
    logic step_en;

`ifdef MANUAL_CLK_EN
    // Two-flop synchroniser plus edge detector. The edge detector runs
    // regardless of manual_clk_sw, so flipping the switch while the button
    // is held does not look like a fresh press. These flops carry no
    // architectural state and settle within three clks of any reset.
    logic btn_meta;
    logic btn_sync;
    logic btn_prev;

    always_ff @(posedge clk) begin
        btn_meta <= bus.pulse_clk_btn;
        btn_sync <= btn_meta;
        btn_prev <= btn_sync;
    end

    assign step_en = bus.manual_clk_sw ? (btn_sync & ~btn_prev) : 1'b1;
`else
    logic unused_manual;
    assign unused_manual = bus.manual_clk_sw ^ bus.pulse_clk_btn;
    assign step_en       = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Architectural state and datapath signals
    // ------------------------------------------------------------------
    state_e          state;
    state_e          state_nxt;
    logic            commit;

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [7:0]      acc;
    logic [7:0]      acc_nxt;
    logic            z_flag;
    logic            n_flag;
    logic            c_flag;
    logic            z_nxt;
    logic            n_nxt;
    logic            c_nxt;

    logic [15:0]     instr;
    opcode_e         opcode;
    alu_func_e       alu_func;
    mem_func_e       mem_func;
    logic [RA_W-1:0] rs;
    logic [7:0]      imm8;
    logic [PC_W-1:0] target;

    logic [7:0]      rf_rd_dat;
    logic            rf_we;
    logic [DA_W-1:0] dm_addr;
    logic [7:0]      dm_rd_dat;
    logic            dm_we;

    logic [7:0]      operand;
    logic [7:0]      alu_res;
    logic            alu_c;
    logic            alu_upd;
    logic            branch_taken;

    assign opcode   = opcode_e'(instr[15:13]);
    assign alu_func = alu_func_e'(instr[12:9]);
    assign mem_func = mem_func_e'(instr[12:10]);
    assign rs       = instr[RA_W-1:0];
    assign imm8     = instr[7:0];
    assign target   = instr[PC_W-1:0];

    assign commit   = step_en && (state == ST_RUN);

    // ------------------------------------------------------------------
    // Memories
    // ------------------------------------------------------------------
    turtle_instruction_memory #(
        .DEPTH (IMEM_DEPTH),
        .AW    (PC_W)
    ) instruction_memory_inst (
        .clk     (clk),
        .rd_addr (pc),
        .rd_dat  (instr),
        .ld_en   (1'b0),
        .ld_addr ('0),
        .ld_dat  ('0)
    );

    turtle_data_memory #(
        .DEPTH (DMEM_DEPTH),
        .AW    (DA_W)
    ) data_memory_inst (
        .clk    (clk),
        .addr   (dm_addr),
        .rd_dat (dm_rd_dat),
        .wr_en  (dm_we),
        .wr_dat (acc)
    );

    turtle_register_file #(
        .NUM (NUM_GPR),
        .AW  (RA_W)
    ) register_file_inst (
        .clk     (clk),
        .rst     (~reset_n),
        .rd_addr (rs),
        .rd_dat  (rf_rd_dat),
        .wr_en   (rf_we),
        .wr_addr (rs),
        .wr_dat  (acc)
    );

    // Register-indirect forms address dmem through R[rs]; the rest use imm8.
    always_comb begin
        dm_addr = imm8[DA_W-1:0];
        if (mem_func == MEM_LOADR || mem_func == MEM_STORER) begin
            dm_addr = rf_rd_dat[DA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign operand = (opcode == OP_ALU_REG) ? rf_rd_dat : imm8;

    always_comb begin
        alu_res = acc;
        alu_c   = 1'b0;
        alu_upd = 1'b1;
        case (alu_func)
            ALU_ADD:  {alu_c, alu_res} = {1'b0, acc} + {1'b0, operand};
            ALU_SUB: begin
                alu_res = acc - operand;
                alu_c   = (acc < operand);
            end
            ALU_AND:  alu_res = acc & operand;
            ALU_OR:   alu_res = acc | operand;
            ALU_XOR:  alu_res = acc ^ operand;
            ALU_NOT:  alu_res = ~acc;
            ALU_SHL: begin
                alu_res = {acc[6:0], 1'b0};
                alu_c   = acc[7];
            end
            ALU_SHR: begin
                alu_res = {1'b0, acc[7:1]};
                alu_c   = acc[0];
            end
            ALU_PASS: alu_res = operand;
            // Functions 9-15 leave both acc and flags alone.
            default:  alu_upd = 1'b0;
        endcase
    end

    always_comb begin
        case (mem_func)
            3'd0:    branch_taken = z_flag;
            3'd1:    branch_taken = ~z_flag;
            3'd2:    branch_taken = n_flag;
            3'd3:    branch_taken = ~n_flag;
            3'd4:    branch_taken = c_flag;
            3'd5:    branch_taken = ~c_flag;
            3'd6:    branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state for pc/acc/flags and memory write strobes
    // ------------------------------------------------------------------
    always_comb begin
        pc_nxt  = pc + PC_W'(1);
        acc_nxt = acc;
        z_nxt   = z_flag;
        n_nxt   = n_flag;
        c_nxt   = c_flag;
        rf_we   = 1'b0;
        dm_we   = 1'b0;
        case (opcode)
            OP_ALU_REG, OP_ALU_IMM: begin
                if (alu_upd) begin
                    acc_nxt = alu_res;
                    z_nxt   = (alu_res == 8'h00);
                    n_nxt   = alu_res[7];
                    c_nxt   = alu_c;
                end
            end
            OP_REG_MEM: begin
                case (mem_func)
                    MEM_LOAD, MEM_LOADR:   acc_nxt = dm_rd_dat;
                    MEM_STORE, MEM_STORER: dm_we   = commit;
                    MEM_GET:               acc_nxt = rf_rd_dat;
                    MEM_PUT:               rf_we   = commit;
                    default: ;
                endcase
            end
            OP_JUMP:   pc_nxt = target;
            OP_BRANCH: begin
                if (branch_taken) begin
                    pc_nxt = target;
                end
            end
            OP_HALT:   pc_nxt = pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc     <= '0;
            acc    <= 8'h00;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            c_flag <= 1'b0;
        end else if (commit) begin
            pc     <= pc_nxt;
            acc    <= acc_nxt;
            z_flag <= z_nxt;
            n_flag <= n_nxt;
            c_flag <= c_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Run/halt FSM: only reset leaves ST_HALT
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (commit && opcode == OP_HALT) begin
            state_nxt = ST_HALT;
        end
    end

    assign bus.acc_out = acc;
    assign bus.halted  = (state == ST_HALT);
endmodule

// File: tb/tb_turtle_cpu_top.sv
// Testbench for turtle_cpu_top: directed program plus random programs in lockstep with an ISA model.
// Latency: model and DUT compared 1 time unit after every rising clk edge.
// Backpressure: none; manual-step section exercised when MANUAL_CLK_EN is defined.
module tb_turtle_cpu_top;
    logic clk = 1'b0;
    logic reset_btn;

    always #5 clk = ~clk;

    turtle_cpu_top_if bus();

    turtle_cpu_top dut (
        .clk       (clk),
        .reset_btn (reset_btn),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    // ISA-level reference state
    logic [15:0] m_imem [1024];
    int          m_dmem [256];
    int          m_reg  [8];
    int          m_acc;
    int          m_pc;
    bit          m_z, m_n, m_c, m_halt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] e_alui(input logic [3:0] f, input logic [7:0] imm);
        return {3'b001, f, 1'b0, imm};
    endfunction
    function automatic logic [15:0] e_mem(input logic [2:0] f, input logic [7:0] fld);
        return {3'b010, f, 2'b00, fld};
    endfunction
    function automatic logic [15:0] e_jmp(input logic [9:0] t);
        return {3'b011, 3'b000, t};
    endfunction
    function automatic logic [15:0] e_br(input logic [2:0] c, input logic [9:0] t);
        return {3'b100, c, t};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_acc = 0; m_z = 0; m_n = 0; m_c = 0; m_halt = 0;
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
    endtask

    task automatic model_step();
        logic [15:0] ins;
        int op, f4, f3, rs, imm, tgt, b, res, nxt;
        bit cy, take;
        if (m_halt) return;
        ins = m_imem[m_pc];
        op  = int'(ins[15:13]); f4 = int'(ins[12:9]); f3 = int'(ins[12:10]);
        rs  = int'(ins[2:0]);   imm = int'(ins[7:0]); tgt = int'(ins[9:0]);
        nxt = (m_pc + 1) % 1024;
        case (op)
            0, 1: begin
                b  = (op == 0) ? m_reg[rs] : imm;
                cy = 0;
                res = m_acc;
                case (f4)
                    0: begin res = (m_acc + b) % 256; cy = (m_acc + b) > 255; end
                    1: begin res = (m_acc - b + 256) % 256; cy = m_acc < b; end
                    2: res = m_acc & b;
                    3: res = m_acc | b;
                    4: res = m_acc ^ b;
                    5: res = 255 - m_acc;
                    6: begin res = (m_acc * 2) % 256; cy = m_acc >= 128; end
                    7: begin res = m_acc / 2; cy = (m_acc % 2) == 1; end
                    8: res = b;
                    default: ;
                endcase
                if (f4 <= 8) begin
                    m_acc = res; m_z = (res == 0); m_n = (res >= 128); m_c = cy;
                end
                m_pc = nxt;
            end
            2: begin
                case (f3)
                    0: m_acc = m_dmem[imm];
                    1: m_dmem[imm] = m_acc;
                    2: m_acc = m_reg[rs];
                    3: m_reg[rs] = m_acc;
                    4: m_acc = m_dmem[m_reg[rs]];
                    5: m_dmem[m_reg[rs]] = m_acc;
                    default: ;
                endcase
                m_pc = nxt;
            end
            3: m_pc = tgt;
            4: begin
                case (f3)
                    0: take = m_z;
                    1: take = !m_z;
                    2: take = m_n;
                    3: take = !m_n;
                    4: take = m_c;
                    5: take = !m_c;
                    6: take = 1;
                    default: take = 0;
                endcase
                m_pc = take ? tgt : nxt;
            end
            7: m_halt = 1;
            default: m_pc = nxt;
        endcase
    endtask

    // One clk: the model follows whatever reset/step the DUT saw on this edge.
    task automatic run_cycle(input bit mstep, input bit do_chk);
        @(posedge clk);
        #1;
        if (reset_btn) model_reset();
        else if (mstep) model_step();
        if (do_chk) begin
            chk("acc", bus.acc_out, m_acc);
            chk("pc", dut.pc, m_pc);
            chk("halted", bus.halted, m_halt);
            chk("flags_znc", {dut.z_flag, dut.n_flag, dut.c_flag}, {m_z, m_n, m_c});
        end
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) run_cycle(1'b1, 1'b1);
    endtask

    logic [9:0] pc_hold;
    int         op_r;

    initial begin
        reset_btn         = 1'b1;
        bus.manual_clk_sw = 1'b0;
        bus.pulse_clk_btn = 1'b0;
        for (int i = 0; i < 256; i++) m_dmem[i] = 0;
        model_reset();

        // ---------------- directed program ----------------
        for (int i = 0; i < 1024; i++) m_imem[i] = 16'h0000;
        m_imem[0]  = e_alui(4'd8, 8'hF0);
        m_imem[1]  = e_alui(4'd0, 8'h20);
        m_imem[2]  = e_alui(4'd1, 8'h10);
        m_imem[3]  = e_alui(4'd8, 8'h5A);
        m_imem[4]  = e_mem(3'd3, 8'd3);
        m_imem[5]  = e_mem(3'd1, 8'h07);
        m_imem[6]  = e_alui(4'd8, 8'h00);
        m_imem[7]  = e_mem(3'd0, 8'h07);
        m_imem[8]  = e_alui(4'd8, 8'h07);
        m_imem[9]  = e_mem(3'd3, 8'd2);
        m_imem[10] = e_alui(4'd8, 8'h11);
        m_imem[11] = e_mem(3'd5, 8'd2);
        m_imem[12] = e_alui(4'd8, 8'h03);
        m_imem[13] = e_mem(3'd3, 8'd1);
        m_imem[14] = e_mem(3'd2, 8'd1);
        m_imem[15] = e_alui(4'd1, 8'h01);
        m_imem[16] = e_mem(3'd3, 8'd1);
        m_imem[17] = e_br(3'd1, 10'd14);
        m_imem[18] = e_jmp(10'h3F0);
        m_imem[10'h3F0] = 16'hE000;
        for (int i = 0; i < 1024; i++) dut.instruction_memory_inst.mem[i] <= m_imem[i];

        run_n(10);
        chk("rst_pc", dut.pc, 0);
        chk("rst_acc", bus.acc_out, 8'h00);
        chk("rst_halted", bus.halted, 0);
        for (int i = 0; i < 8; i++) chk("rst_gpr", dut.register_file_inst.mem[i], 8'h00);
        reset_btn = 1'b0;

        run_n(2);
        chk("add_acc", bus.acc_out, 8'h10);
        chk("add_c", dut.c_flag, 1);
        chk("add_z", dut.z_flag, 0);
        run_n(1);
        chk("sub_acc", bus.acc_out, 8'h00);
        chk("sub_z", dut.z_flag, 1);
        chk("sub_c", dut.c_flag, 0);
        run_n(5);
        chk("load_acc", bus.acc_out, 8'h5A);
        chk("put_r3", dut.register_file_inst.mem[3], 8'h5A);
        chk("store_d7", dut.data_memory_inst.mem[7], 8'h5A);
        run_n(4);
        chk("put_r2", dut.register_file_inst.mem[2], 8'h07);
        chk("storer_d7", dut.data_memory_inst.mem[7], 8'h11);
        run_n(14);
        chk("loop_r1", dut.register_file_inst.mem[1], 8'h00);
        chk("loop_exit_pc", dut.pc, 18);
        run_n(1);
        chk("jump_pc", dut.pc, 10'h3F0);
        run_n(1);
        chk("halt_flag", bus.halted, 1);
        run_n(5);
        chk("halt_pc_hold", dut.pc, 10'h3F0);
        chk("halt_still", bus.halted, 1);

        // ---------------- random programs ----------------
        // Addresses 0-6 hold a loop writing dmem[a]=a for all a, so every
        // dmem byte is known before random code can read it.
        reset_btn = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            op_r = $urandom_range(0, 7);
            if (op_r == 7 && $urandom_range(0, 31) != 0) op_r = 1;
            m_imem[i] = {op_r[2:0], 13'($urandom)};
        end
        m_imem[0] = e_alui(4'd8, 8'h00);
        m_imem[1] = e_mem(3'd3, 8'd0);
        m_imem[2] = e_mem(3'd2, 8'd0);
        m_imem[3] = e_mem(3'd5, 8'd0);
        m_imem[4] = e_alui(4'd0, 8'h01);
        m_imem[5] = e_mem(3'd3, 8'd0);
        m_imem[6] = e_br(3'd1, 10'd2);
        for (int i = 0; i < 1024; i++) dut.instruction_memory_inst.mem[i] <= m_imem[i];
        run_n(3);
        chk("rst_clears_halt", bus.halted, 0);
        reset_btn = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            run_cycle(1'b1, 1'b1);
            if (cyc == 601) begin
                chk("midrst_pc", dut.pc, 0);
                chk("midrst_acc", bus.acc_out, 8'h00);
                for (int a = 0; a < 8; a++) chk("midrst_dmem_kept", dut.data_memory_inst.mem[a], m_dmem[a]);
            end
            reset_btn = (cyc == 600) || ($urandom_range(0, 499) == 0);
        end
        for (int i = 0; i < 8; i++) chk("final_gpr", dut.register_file_inst.mem[i], m_reg[i]);
        for (int a = 0; a < 256; a++) chk("final_dmem", dut.data_memory_inst.mem[a], m_dmem[a]);

        // ---------------- stepping control ----------------
        reset_btn = 1'b1;
        run_n(2);
        reset_btn = 1'b0;
        run_n(20);
`ifdef MANUAL_CLK_EN
        bus.pulse_clk_btn = 1'b1;
        run_n(4);
        bus.manual_clk_sw = 1'b1;
        for (int k = 0; k < 10; k++) run_cycle(1'b0, 1'b1);
        bus.pulse_clk_btn = 1'b0;
        pc_hold = 10'(m_pc);
        for (int k = 0; k < 100; k++) run_cycle(1'b0, 1'b0);
        chk("man_idle_pc", dut.pc, pc_hold);
        for (int p = 0; p < 3; p++) begin
            bus.pulse_clk_btn = 1'b1;
            for (int k = 0; k < 5; k++) run_cycle(1'b0, 1'b0);
            bus.pulse_clk_btn = 1'b0;
            for (int k = 0; k < 5; k++) run_cycle(1'b0, 1'b0);
        end
        for (int s = 0; s < 3; s++) model_step();
        run_cycle(1'b0, 1'b1);
        chk("man_gpr0", dut.register_file_inst.mem[0], m_reg[0]);
        bus.manual_clk_sw = 1'b0;
        run_n(10);
`else
        bus.manual_clk_sw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.pulse_clk_btn = 1'($urandom_range(0, 1));
            run_cycle(1'b1, 1'b1);
        end
        bus.manual_clk_sw = 1'b0;
        pc_hold = 10'(m_pc);
        chk("free_run_pc", dut.pc, pc_hold);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
